mem_rmw_mask_ctrl: RTL and testbench

emulate masked writes on an unmasked 1R1W macro by read-modify-write, and pass user reads through to the macro.
REQ-005 FSM states SHALL be IDLE and MERGE.
REQ-006 IDLE, full-mask write (W0_mask all ones):
  - W0_ready=1.
  - Same cycle: CENB=0, AB=W0_addr, DB=W0_data.
  - Next state IDLE.
REQ-007 IDLE, zero-mask write: W0_ready=1, accepted, no macro access.
REQ-008 IDLE, partial-mask write with R0_en=0:
  - W0_ready=1.
  - Same cycle: CENA=0, AA=W0_addr.
  - Latch address, data and mask; next state MERGE.
REQ-009 IDLE, partial-mask write with R0_en=1: the user read SHALL win port A, W0_ready=0, and the write is not accepted.
REQ-010 MERGE:
  - W0_ready=0.
  - CENB=0, AB=latched address.
  - DB = lanes selected by the latched mask from latched data, all other lanes from QA.
  - Next state IDLE.
REQ-011 User read, any state: CENA=0, AA=R0_addr; R0_data=QA in the following cycle.
REQ-012 Forwarding: if CENA=0 and CENB=0 in the same cycle with AA==AB, the next-cycle R0_data SHALL equal that cycle's DB, not QA.
REQ-013 Outside forwarding cycles, R0_data SHALL equal QA.
REQ-014 CENA and CENB SHALL be 1 whenever no access is required.
REQ-015 Throughput:
  - Full-mask and zero-mask writes: 1 per cycle.
  - Partial-mask writes: 1 per 2 cycles.
REQ-016 Back-to-back partial writes to the same address SHALL see the prior merged value, because that value is committed in MERGE before the next RMW read is issued.

Reset
REQ-017 While rst_n=0:
  - State is forced to IDLE.
  - Forward flag cleared; CENA=1, CENB=1, W0_ready=0.
  - AA, AB and DB are driven to 0.
REQ-018 Reset asserted in MERGE SHALL drop the pending write: no macro write occurs.
REQ-019 After reset, R0_data equals QA until the first read completes; R0_data has no defined reset value.
REQ-020 W0_ready SHALL be 1 in the first cycle after rst_n rises, subject to REQ-009.

Structure
REQ-021 Package mem_rmw_pkg SHALL hold the ADDR_W/DATA_W/MASK_GRAN defaults, MASK_W and the FSM state enum.
REQ-022 Sub-module mem_rmw_merge SHALL be a combinational lane merge: (old, new, mask) -> merged.
REQ-023 Registers SHALL be: state, latched addr/data/mask, forward flag and forward data.

Verification
REQ-024 Full write, addr 3, data 0x1122334455667788, mask 0xFF -> CENB=0 the same cycle; a later read of addr 3 returns 0x1122334455667788.
REQ-025 Addr 3 holds 0x1122334455667788; write data 0xAAAAAAAAAAAAAAAA, mask 0x0F ->
  - Cycle 0: CENA=0.
  - Cycle 1: CENB=0 with DB=0x11223344AAAAAAAA.
  - W0_ready=0 in cycle 1.
REQ-026 Partial write and R0_en=1 in the same cycle -> W0_ready=0, read serviced; the write is accepted on the next cycle.
REQ-027 In MERGE, R0_en on the same address -> next-cycle R0_data equals the merged DB.
REQ-028 Full write to addr 7 with a concurrent read of addr 7

---
 rtl/mem_rmw_pkg.sv | 15 +
 rtl/mem_rmw_merge.sv | 23 ++
 rtl/mem_rmw_mask_ctrl.sv | 119 +++++++++++
 tb/tb_mem_rmw_mask_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rmw_pkg.sv
// Shared defaults and FSM encoding for the masked-write emulation around an
// unmasked 1R1W memory macro.
package mem_rmw_pkg;

   localparam int RMW_ADDR_W    = 5;
   localparam int RMW_DATA_W    = 64;
   localparam int RMW_MASK_GRAN = 8;
   localparam int RMW_MASK_W    = RMW_DATA_W / RMW_MASK_GRAN;

   typedef enum logic {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } rmw_state_e;

endpackage

// File: rtl/mem_rmw_merge.sv
// Lane merge: each mask bit selects its lane from new_data, otherwise the lane
// keeps the value read back from the macro.
module mem_rmw_merge
   import mem_rmw_pkg::*;
#(
   parameter int  DATA_W    = RMW_DATA_W,
   parameter int  MASK_GRAN = RMW_MASK_GRAN,
   localparam int MASK_W    = DATA_W / MASK_GRAN
) (
   input  logic [DATA_W-1:0] old_data,
   input  logic [DATA_W-1:0] new_data,
   input  logic [MASK_W-1:0] mask,
   output logic [DATA_W-1:0] merged
);

   always_comb begin
      merged = old_data;
      for (int i = 0; i < MASK_W; i++) begin
         if (mask[i]) merged[i*MASK_GRAN +: MASK_GRAN] = new_data[i*MASK_GRAN +: MASK_GRAN];
      end
   end

endmodule

// File: rtl/mem_rmw_mask_ctrl.sv
// Masked-write front end for an unmasked 1R1W macro: full/zero masks go straight
// through, partial masks take a read cycle plus a merge-and-write cycle.
module mem_rmw_mask_ctrl
   import mem_rmw_pkg::*;
#(
   parameter int  ADDR_W    = RMW_ADDR_W,
   parameter int  DATA_W    = RMW_DATA_W,
   parameter int  MASK_GRAN = RMW_MASK_GRAN,
   localparam int MASK_W    = DATA_W / MASK_GRAN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] R0_addr,
   input  logic              R0_en,
   output logic [DATA_W-1:0] R0_data,
   input  logic [ADDR_W-1:0] W0_addr,
   input  logic              W0_en,
   input  logic [DATA_W-1:0] W0_data,
   input  logic [MASK_W-1:0] W0_mask,
   output logic              W0_ready,
   output logic [ADDR_W-1:0] AA,
   output logic              CENA,
   input  logic [DATA_W-1:0] QA,
   output logic [ADDR_W-1:0] AB,
   output logic              CENB,
   output logic [DATA_W-1:0] DB
);

   rmw_state_e        state_q, state_d;
   logic              mask_full, mask_part, part_go;
   logic [ADDR_W-1:0] wr_addr_p1;
   logic [DATA_W-1:0] wr_data_p1;
   logic [MASK_W-1:0] wr_mask_p1;
   logic              fwd_vld_p1;
   logic [DATA_W-1:0] fwd_data_p1;
   logic [DATA_W-1:0] merged;

   assign mask_full = &W0_mask;
   assign mask_part = |W0_mask && !mask_full;
   // A user read owns port A, so a partial write only starts when no read is pending.
   assign part_go   = rst_n && (state_q == IDLE) && W0_en && mask_part && !R0_en;

   mem_rmw_merge #(
      .DATA_W    (DATA_W),
      .MASK_GRAN (MASK_GRAN)
   ) u_merge (
      .old_data (QA),
      .new_data (wr_data_p1),
      .mask     (wr_mask_p1),
      .merged   (merged)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (part_go) state_d = MERGE;
         MERGE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      W0_ready = 1'b0;
      CENA     = 1'b1;
      AA       = '0;
      CENB     = 1'b1;
      AB       = '0;
      DB       = '0;
      if (rst_n) begin
         if (R0_en) begin
            CENA = 1'b0;
            AA   = R0_addr;
         end
         case (state_q)
            IDLE: begin
               W0_ready = !(W0_en && mask_part && R0_en);
               if (W0_en && mask_full) begin
                  CENB = 1'b0;
                  AB   = W0_addr;
                  DB   = W0_data;
               end else if (part_go) begin
                  CENA = 1'b0;
                  AA   = W0_addr;
               end
            end
            MERGE: begin
               CENB = 1'b0;
               AB   = wr_addr_p1;
               DB   = merged;
            end
            default: ;
         endcase
      end
   end

   // p0 -> p1: capture the RMW request and any same-address read/write collision.
   always_ff @(posedge clk) begin
      if (!rst_n) fwd_vld_p1 <= 1'b0;
      else        fwd_vld_p1 <= !CENA && !CENB && (AA == AB);
   end

   always_ff @(posedge clk) begin
      fwd_data_p1 <= DB;
      if (part_go) begin
         wr_addr_p1 <= W0_addr;
         wr_data_p1 <= W0_data;
         wr_mask_p1 <= W0_mask;
      end
   end

   // The macro returns pre-write data on a collision, so the written word is replayed.
   assign R0_data = fwd_vld_p1 ? fwd_data_p1 : QA;

endmodule

// File: tb/tb_mem_rmw_mask_ctrl.sv
// Directed bench for mem_rmw_mask_ctrl with a behavioural 1R1W macro and a
// reference memory feeding a read-data scoreboard.
module tb_mem_rmw_mask_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  R0_addr;
   logic        R0_en;
   logic [63:0] R0_data;
   logic [4:0]  W0_addr;
   logic        W0_en;
   logic [63:0] W0_data;
   logic [7:0]  W0_mask;
   logic        W0_ready;
   logic [4:0]  AA;
   logic        CENA;
   logic [63:0] QA = '0;
   logic [4:0]  AB;
   logic        CENB;
   logic [63:0] DB;

   logic [63:0] mem     [32] = '{default: '0};
   logic [63:0] ref_mem [32] = '{default: '0};
   logic [63:0] rd_q [$];
   logic        rd_pend = 1'b0;

   logic        m_merge = 1'b0;
   logic [4:0]  m_addr  = '0;
   logic [63:0] m_data  = '0;
   logic [7:0]  m_mask  = '0;

   logic        obs_cena, obs_cenb, obs_ready;
   logic [4:0]  obs_aa;
   logic [63:0] obs_db, obs_rdata;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_rmw_mask_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .R0_addr  (R0_addr),
      .R0_en    (R0_en),
      .R0_data  (R0_data),
      .W0_addr  (W0_addr),
      .W0_en    (W0_en),
      .W0_data  (W0_data),
      .W0_mask  (W0_mask),
      .W0_ready (W0_ready),
      .AA       (AA),
      .CENA     (CENA),
      .QA       (QA),
      .AB       (AB),
      .CENB     (CENB),
      .DB       (DB)
   );

   // Unmasked 1R1W macro: a read colliding with a write returns the old word.
   always @(posedge clk) begin
      if (!CENA) QA <= mem[AA];
      if (!CENB) mem[AB] <= DB;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic re, input logic [4:0] ra, input logic we,
                      input logic [4:0] wa, input logic [63:0] wd, input logic [7:0] wm);
      logic        full, part, e_ready, e_cena, e_cenb, pushed, n_merge;
      logic [4:0]  e_aa, e_ab;
      logic [63:0] e_db;
      R0_en = re; R0_addr = ra; W0_en = we; W0_addr = wa; W0_data = wd; W0_mask = wm;
      full = (wm == 8'hFF);
      part = (wm != 8'h00) && !full;
      e_ready = 1'b0; e_cena = 1'b1; e_cenb = 1'b1; e_aa = '0; e_ab = '0; e_db = '0;
      pushed = 1'b0; n_merge = 1'b0;
      if (rst_n) begin
         if (m_merge) begin
            e_db = ref_mem[m_addr];
            for (int i = 0; i < 8; i++) if (m_mask[i]) e_db[i*8 +: 8] = m_data[i*8 +: 8];
            e_cenb = 1'b0; e_ab = m_addr;
            ref_mem[m_addr] = e_db;
         end else begin
            e_ready = !(we && part && re);
            if (we && e_ready && full) begin
               e_cenb = 1'b0; e_ab = wa; e_db = wd;
               ref_mem[wa] = wd;
            end else if (we && e_ready && part) begin
               e_cena = 1'b0; e_aa = wa; n_merge = 1'b1;
               m_addr = wa; m_data = wd; m_mask = wm;
            end
         end
         if (re) begin
            e_cena = 1'b0; e_aa = ra;
            rd_q.push_back(ref_mem[ra]);
            pushed = 1'b1;
         end
      end
      m_merge = n_merge;
      @(negedge clk);
      if (rd_pend) begin
         obs_rdata = R0_data;
         chk("r0_data", R0_data, rd_q.pop_front());
      end
      chk("w0_ready", W0_ready, e_ready);
      chk("cena", CENA, e_cena);
      chk("cenb", CENB, e_cenb);
      if (!e_cena || !rst_n) chk("aa", AA, e_aa);
      if (!e_cenb || !rst_n) begin
         chk("ab", AB, e_ab);
         chk("db", DB, e_db);
      end
      obs_cena = CENA; obs_cenb = CENB; obs_ready = W0_ready; obs_aa = AA; obs_db = DB;
      rd_pend = pushed;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 5'd0, 1'b0, 5'd0, 64'h0, 8'h00);
   endtask

   initial begin
      rst_n = 1'b0;
      R0_en = 1'b0; R0_addr = '0; W0_en = 1'b0; W0_addr = '0; W0_data = '0; W0_mask = '0;
      @(posedge clk);
      #1;
      // Reset holds every strobe inactive even with requests present.
      cyc(1'b1, 5'd3, 1'b1, 5'd3, 64'hFFFF_0000_FFFF_0000, 8'hFF);
      chk("rst_cenb", obs_cenb, 1'b1);
      cyc(1'b0, 5'd0, 1'b1, 5'd4, 64'h1, 8'h0F);
      rst_n = 1'b1;

      // Full write goes straight to port B, then read it back.
      cyc(1'b0, 5'd0, 1'b1, 5'd3, 64'h1122334455667788, 8'hFF);
      chk("req20_ready", obs_ready, 1'b1);
      chk("req24_cenb", obs_cenb, 1'b0);
      cyc(1'b1, 5'd3, 1'b0, 5'd0, 64'h0, 8'h00);
      idle();
      chk("req24_rd", obs_rdata, 64'h1122334455667788);

      // Partial write: read cycle then merged write.
      cyc(1'b0, 5'd0, 1'b1, 5'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
      chk("req25_c0_cena", obs_cena, 1'b0);
      idle();
      chk("req25_c1_cenb", obs_cenb, 1'b0);
      chk("req25_c1_db", obs_db, 64'h11223344AAAAAAAA);
      chk("req25_c1_ready", obs_ready, 1'b0);
      cyc(1'b1, 5'd3, 1'b0, 5'd0, 64'h0, 8'h00);
      idle();
      chk("req25_rd", obs_rdata, 64'h11223344AAAAAAAA);

      // Read beats a partial write for port A; the write retries next cycle.
      cyc(1'b1, 5'd5, 1'b1, 5'd4, 64'hDEADBEEFCAFEF00D, 8'hF0);
      chk("req26_ready", obs_ready, 1'b0);
      chk("req26_aa", obs_aa, 5'd5);
      cyc(1'b0, 5'd0, 1'b1, 5'd4, 64'hDEADBEEFCAFEF00D, 8'hF0);
      chk("req26_accept", obs_ready, 1'b1);
      idle();
      cyc(1'b1, 5'd4, 1'b0, 5'd0, 64'h0, 8'h00);
      idle();
      chk("req26_rd", obs_rdata, 64'hDEADBEEF00000000);

      // Read during MERGE of the same address sees the merged word.
      cyc(1'b0, 5'd0, 1'b1, 5'd6, 64'h0123456789ABCDEF, 8'hFF);
      cyc(1'b0, 5'd0, 1'b1, 5'd6, 64'hFFFFFFFFFFFFFFFF, 8'h3C);
      cyc(1'b1, 5'd6, 1'b0, 5'd0, 64'h0, 8'h00);
      idle();
      chk("req27_rd", obs_rdata, 64'h0123FFFFFFFFCDEF);

      // Full write and read of the same address in one cycle.
      cyc(1'b1, 5'd7, 1'b1, 5'd7, 64'h5A5A5A5A5A5A5A5A, 8'hFF);
      idle();
      chk("req28_rd", obs_rdata, 64'h5A5A5A5A5A5A5A5A);

      // Back-to-back partial writes to one address; the second stalls during MERGE.
      cyc(1'b0, 5'd0, 1'b1, 5'd9, 64'h0000000000000011, 8'h01);
      cyc(1'b0, 5'd0, 1'b1, 5'd9, 64'h2200000000000000, 8'h80);
      chk("req16_stall", obs_ready, 1'b0);
      cyc(1'b0, 5'd0, 1'b1, 5'd9, 64'h2200000000000000, 8'h80);
      idle();
      cyc(1'b1, 5'd9, 1'b0, 5'd0, 64'h0, 8'h00);
      idle();
      chk("req16_rd", obs_rdata, 64'h2200000000000011);

      // Zero-mask write touches nothing; full writes stream one per cycle.
      cyc(1'b0, 5'd0, 1'b1, 5'd10, 64'hFFFFFFFFFFFFFFFF, 8'h00);
      chk("zero_cena", obs_cena, 1'b1);
      chk("zero_cenb", obs_cenb, 1'b1);
      cyc(1'b0, 5'd0, 1'b1, 5'd11, 64'h0B0B0B0B0B0B0B0B, 8'hFF);
      cyc(1'b0, 5'd0, 1'b1, 5'd12, 64'h0C0C0C0C0C0C0C0C, 8'hFF);
      chk("b2b_ready", obs_ready, 1'b1);
      cyc(1'b1, 5'd10, 1'b0, 5'd0, 64'h0, 8'h00);
      cyc(1'b1, 5'd11, 1'b0, 5'd0, 64'h0, 8'h00);
      cyc(1'b1, 5'd12, 1'b0, 5'd0, 64'h0, 8'h00);
      idle();

      // Reset during MERGE drops the pending write.
      cyc(1'b0, 5'd0, 1'b1, 5'd3, 64'h0, 8'h0F);
      rst_n = 1'b0;
      idle();
      chk("req29_cenb", obs_cenb, 1'b1);
      rst_n = 1'b1;
      cyc(1'b1, 5'd3, 1'b0, 5'd0, 64'h0, 8'h00);
      chk("req29_ready", obs_ready, 1'b1);
      idle();
      chk("req29_rd", obs_rdata, 64'h11223344AAAAAAAA);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
